// File: rtl/mnist_pkg.sv
// Shared constants, FSM state type and byte-lane helper for maxpool_reader.
// The build macro MAXPOOL_RELU_EN (see max4_s8) does not affect this package.
package mnist_pkg;

   localparam int IN_DIM       = 26;
   localparam int IN_ROW_WORDS = 7;
   localparam int OUT_DIM      = 13;
   localparam int OUT_WORDS    = 43;
   localparam int CH1_OUT_BASE = OUT_WORDS;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_REQ,
      LOAD_CAP,
      POOL,
      FLUSH,
      DONE
   } state_e;

   // Lane 0 is the most significant byte of a memory word.
   function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
      return word[8*(3-int'(lane)) +: 8];
   endfunction

endpackage

// File: rtl/max4_s8.sv
// Combinational signed max of four int8 values.
// Build macro MAXPOOL_RELU_EN clamps every candidate to max(0, x) before the compare.
module max4_s8 (
   input  logic signed [7:0] a,
   input  logic signed [7:0] b,
   input  logic signed [7:0] c,
   input  logic signed [7:0] d,
   output logic signed [7:0] y
);

   logic signed [7:0] a_c, b_c, c_c, d_c;
   logic signed [7:0] m_ab, m_cd;

   function automatic logic signed [7:0] clamp(input logic signed [7:0] x);
`ifdef MAXPOOL_RELU_EN
      return x[7] ? 8'sd0 : x;
`else
      return x;
`endif
   endfunction

   always_comb begin
      a_c  = clamp(a);
      b_c  = clamp(b);
      c_c  = clamp(c);
      d_c  = clamp(d);
      m_ab = (a_c > b_c) ? a_c : b_c;
      m_cd = (c_c > d_c) ? c_c : d_c;
      y    = (m_ab > m_cd) ? m_ab : m_cd;
   end

endmodule

// File: rtl/maxpool_reader.sv
// Reads two 26x26 int8 maps from M1/M2, 2x2 stride-2 max-pools them and packs the
// 13x13 results into M3. Build macro MAXPOOL_RELU_EN enables the ReLU clamp in max4_s8.
module maxpool_reader
   import mnist_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        finish,
   output logic        M1_R_req,
   output logic [31:0] M1_addr,
   input  logic [31:0] M1_R_data,
   output logic        M2_R_req,
   output logic [31:0] M2_addr,
   input  logic [31:0] M2_R_data,
   output logic [3:0]  M3_W_req,
   output logic [31:0] M3_addr,
   output logic [31:0] M3_W_data
);

   state_e      state_q, state_d;
   logic        ch_q, ch_d;
   logic [3:0]  r_q, r_d;
   logic [3:0]  k_q, k_d;
   logic [3:0]  c_q, c_d;
   logic [7:0]  byte_cnt_q, byte_cnt_d;
   logic [31:0] pack_q, pack_d;
   logic [7:0]  line_a_q [IN_DIM];
   logic [7:0]  line_a_d [IN_DIM];
   logic [7:0]  line_b_q [IN_DIM];
   logic [7:0]  line_b_d [IN_DIM];
   logic [3:0]  w_req_q, w_req_d;
   logic [31:0] w_addr_q, w_addr_d;
   logic [31:0] w_data_q, w_data_d;

   logic [31:0] rd_addr;
   logic [31:0] rd_data;
   logic [31:0] out_base;
   logic [7:0]  pool_val;

   // Rows 2r and 2r+1 are contiguous, so load word k of the pair sits at 14*r + k.
   assign rd_addr  = 32'(r_q) * 32'(2*IN_ROW_WORDS) + 32'(k_q);
   assign rd_data  = ch_q ? M2_R_data : M1_R_data;
   assign out_base = ch_q ? 32'(CH1_OUT_BASE) : 32'd0;

   assign finish    = (state_q == DONE);
   assign M1_R_req  = (state_q == LOAD_REQ) && !ch_q;
   assign M2_R_req  = (state_q == LOAD_REQ) && ch_q;
   assign M1_addr   = M1_R_req ? rd_addr : 32'd0;
   assign M2_addr   = M2_R_req ? rd_addr : 32'd0;
   assign M3_W_req  = w_req_q;
   assign M3_addr   = w_addr_q;
   assign M3_W_data = w_data_q;

   max4_s8 u_max4 (
      .a (line_a_q[{c_q, 1'b0}]),
      .b (line_a_q[{c_q, 1'b1}]),
      .c (line_b_q[{c_q, 1'b0}]),
      .d (line_b_q[{c_q, 1'b1}]),
      .y (pool_val)
   );

   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      r_d        = r_q;
      k_d        = k_q;
      c_d        = c_q;
      byte_cnt_d = byte_cnt_q;
      pack_d     = pack_q;
      line_a_d   = line_a_q;
      line_b_d   = line_b_q;
      w_req_d    = 4'h0;
      w_addr_d   = w_addr_q;
      w_data_d   = w_data_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = LOAD_REQ;
               ch_d       = 1'b0;
               r_d        = 4'd0;
               k_d        = 4'd0;
               byte_cnt_d = 8'd0;
               pack_d     = 32'd0;
            end
         end
         LOAD_REQ: state_d = LOAD_CAP;
         LOAD_CAP: begin
            // Words 0..6 fill line A, 7..13 fill line B; padding bytes 26-27 are dropped.
            for (int w = 0; w < IN_ROW_WORDS; w++) begin
               for (int l = 0; l < 4; l++) begin
                  if (4*w + l < IN_DIM) begin
                     if (k_q == 4'(w))
                        line_a_d[5'(4*w + l)] = lane_byte(rd_data, 2'(l));
                     if (k_q == 4'(w + IN_ROW_WORDS))
                        line_b_d[5'(4*w + l)] = lane_byte(rd_data, 2'(l));
                  end
               end
            end
            if (k_q == 4'(2*IN_ROW_WORDS - 1)) begin
               state_d = POOL;
               c_d     = 4'd0;
            end else begin
               k_d     = k_q + 4'd1;
               state_d = LOAD_REQ;
            end
         end
         POOL: begin
            pack_d     = {pack_q[23:0], pool_val};
            byte_cnt_d = byte_cnt_q + 8'd1;
            if (byte_cnt_q[1:0] == 2'd3) begin
               w_req_d  = 4'hF;
               w_addr_d = out_base + 32'(byte_cnt_q[7:2]);
               w_data_d = {pack_q[23:0], pool_val};
            end
            if (c_q == 4'(OUT_DIM - 1)) begin
               if (r_q < 4'(OUT_DIM - 1)) begin
                  r_d     = r_q + 4'd1;
                  k_d     = 4'd0;
                  state_d = LOAD_REQ;
               end else begin
                  state_d = FLUSH;
               end
            end else begin
               c_d = c_q + 4'd1;
            end
         end
         FLUSH: begin
            // Partial word: newest byte is in pack_q[7:0], shift the valid ones to the top.
            if (byte_cnt_q[1:0] != 2'd0) begin
               w_addr_d = out_base + 32'(byte_cnt_q[7:2]);
               case (byte_cnt_q[1:0])
                  2'd1:    begin w_req_d = 4'b1000; w_data_d = {pack_q[7:0], 24'h0};  end
                  2'd2:    begin w_req_d = 4'b1100; w_data_d = {pack_q[15:0], 16'h0}; end
                  default: begin w_req_d = 4'b1110; w_data_d = {pack_q[23:0], 8'h0};  end
               endcase
            end
            if (!ch_q) begin
               ch_d       = 1'b1;
               r_d        = 4'd0;
               k_d        = 4'd0;
               byte_cnt_d = 8'd0;
               pack_d     = 32'd0;
               state_d    = LOAD_REQ;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         ch_q       <= 1'b0;
         r_q        <= 4'd0;
         k_q        <= 4'd0;
         c_q        <= 4'd0;
         byte_cnt_q <= 8'd0;
         pack_q     <= 32'd0;
         for (int i = 0; i < IN_DIM; i++) begin
            line_a_q[i] <= 8'd0;
            line_b_q[i] <= 8'd0;
         end
         w_req_q    <= 4'h0;
         w_addr_q   <= 32'd0;
         w_data_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         r_q        <= r_d;
         k_q        <= k_d;
         c_q        <= c_d;
         byte_cnt_q <= byte_cnt_d;
         pack_q     <= pack_d;
         line_a_q   <= line_a_d;
         line_b_q   <= line_b_d;
         w_req_q    <= w_req_d;
         w_addr_q   <= w_addr_d;
         w_data_q   <= w_data_d;
      end
   end

endmodule

// File: tb/tb_maxpool_reader.sv
// Directed testbench for maxpool_reader: memory models for M1/M2, write/read monitors,
// a golden pooling model feeding an expected queue, and one task per scenario.
module tb_maxpool_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        finish;
   logic        M1_R_req, M2_R_req;
   logic [31:0] M1_addr, M2_addr;
   logic [31:0] M1_R_data = 32'd0;
   logic [31:0] M2_R_data = 32'd0;
   logic [3:0]  M3_W_req;
   logic [31:0] M3_addr, M3_W_data;

   logic [7:0]  map [2][26][26];
   logic [31:0] mem [2][182];
   logic [67:0] exp_q[$];
   logic [67:0] act_q[$];
   logic [32:0] rd_q[$];
   int          wr_in_rst = 0;
   int          iso_err = 0;
   int          bad_rd = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   maxpool_reader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .finish    (finish),
      .M1_R_req  (M1_R_req),
      .M1_addr   (M1_addr),
      .M1_R_data (M1_R_data),
      .M2_R_req  (M2_R_req),
      .M2_addr   (M2_addr),
      .M2_R_data (M2_R_data),
      .M3_W_req  (M3_W_req),
      .M3_addr   (M3_addr),
      .M3_W_data (M3_W_data)
   );

   // ---------------- clock ----------------
   initial forever #5 clk = ~clk;

   // ---------------- memory models: data one cycle after the request ----------------
   always @(posedge clk) begin
      M1_R_data <= (M1_R_req && M1_addr < 32'd182) ? mem[0][M1_addr[7:0]] : 32'hDEADBEEF;
      M2_R_data <= (M2_R_req && M2_addr < 32'd182) ? mem[1][M2_addr[7:0]] : 32'hDEADBEEF;
   end

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (M3_W_req != 4'h0) begin
         act_q.push_back({M3_W_req, M3_addr, M3_W_data});
         if (!rst) wr_in_rst++;
      end
      if (M1_R_req) begin
         rd_q.push_back({1'b0, M1_addr});
         if (M1_addr >= 32'd182) bad_rd++;
      end
      if (M2_R_req) begin
         rd_q.push_back({1'b1, M2_addr});
         if (M2_addr >= 32'd182) bad_rd++;
      end
      if ((M1_R_req && M2_R_req) || (!M1_R_req && M1_addr != 32'd0) ||
          (!M2_R_req && M2_addr != 32'd0))
         iso_err++;
   end

   // ---------------- golden model ----------------
   function automatic logic [7:0] gold_px(input int ch, input int oy, input int ox);
      logic signed [7:0] best, v;
      best = 8'sh80;
      for (int dy = 0; dy < 2; dy++) begin
         for (int dx = 0; dx < 2; dx++) begin
            v = map[ch][2*oy+dy][2*ox+dx];
`ifdef MAXPOOL_RELU_EN
            if (v[7]) v = 8'sd0;
`endif
            if (v > best) best = v;
         end
      end
      return best;
   endfunction

   task automatic build_exp();
      logic [31:0] d;
      int idx;
      exp_q.delete();
      for (int ch = 0; ch < 2; ch++) begin
         for (int i = 0; i < 43; i++) begin
            d = 32'd0;
            for (int j = 0; j < 4; j++) begin
               idx = 4*i + j;
               if (idx < 169) d[8*(3-j) +: 8] = gold_px(ch, idx / 13, idx % 13);
            end
            exp_q.push_back({(i == 42) ? 4'h8 : 4'hF, 32'(ch*43 + i), d});
         end
      end
   endtask

   // kind 0: zeros, 1: ramp / negated ramp, 2: signed corner windows on a zero map
   task automatic set_maps(input int kind);
      logic [31:0] word;
      int x;
      for (int ch = 0; ch < 2; ch++)
         for (int y = 0; y < 26; y++)
            for (int xx = 0; xx < 26; xx++) begin
               if (kind == 1)
                  map[ch][y][xx] = (ch == 0) ? 8'((y*26 + xx) % 100) : 8'(-((y*26 + xx) % 100));
               else
                  map[ch][y][xx] = 8'h00;
            end
      if (kind == 2) begin
         map[0][0][0] = 8'h80; map[0][0][1] = 8'h7F; map[0][1][0] = 8'hFF; map[0][1][1] = 8'h00;
         map[0][0][2] = 8'h90; map[0][0][3] = 8'h85; map[0][1][2] = 8'h85; map[0][1][3] = 8'h90;
         map[1][0][0] = 8'h80; map[1][0][1] = 8'h80; map[1][1][0] = 8'h80; map[1][1][1] = 8'h80;
      end
      for (int ch = 0; ch < 2; ch++)
         for (int y = 0; y < 26; y++)
            for (int w = 0; w < 7; w++) begin
               word = 32'd0;
               for (int l = 0; l < 4; l++) begin
                  x = 4*w + l;
                  word[8*(3-l) +: 8] = (x < 26) ? map[ch][y][x] : 8'h5A;
               end
               mem[ch][y*7 + w] = word;
            end
      build_exp();
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_logs();
      @(posedge clk);
      #1;
      act_q.delete();
      rd_q.delete();
   endtask

   task automatic run_job(input bit hold, output int cycles);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      cycles = 1;
      while (!finish && cycles < 3000) begin
         @(negedge clk);
         cycles++;
      end
      repeat (3) @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++; if (finish !== 1'b0) $display("FAIL reset_finish: got %b want 0", finish); else n_pass++;
      n_checks++; if (M1_R_req !== 1'b0) $display("FAIL reset_m1_req: got %b want 0", M1_R_req); else n_pass++;
      n_checks++; if (M2_R_req !== 1'b0) $display("FAIL reset_m2_req: got %b want 0", M2_R_req); else n_pass++;
      n_checks++; if ({M1_addr, M2_addr} !== 64'd0) $display("FAIL reset_rd_addr: got %h %h want 0 0", M1_addr, M2_addr); else n_pass++;
      n_checks++; if (M3_W_req !== 4'h0) $display("FAIL reset_w_req: got %h want 0", M3_W_req); else n_pass++;
      n_checks++; if ({M3_addr, M3_W_data} !== 64'd0) $display("FAIL reset_w_addr_data: got %h %h want 0 0", M3_addr, M3_W_data); else n_pass++;
      rst = 1'b1;
      clear_logs();
      repeat (10) @(negedge clk);
      n_checks++; if (rd_q.size() !== 0) $display("FAIL idle_no_reads: got %0d reads want 0", rd_q.size()); else n_pass++;
   endtask

   task automatic test_zero_maps();
      int cyc;
      logic [67:0] a, e;
      set_maps(0);
      clear_logs();
      run_job(1'b0, cyc);
      n_checks++; if (cyc < 1066 || cyc > 1070) $display("FAIL zero_latency: got %0d cycles want 1068+-2", cyc); else n_pass++;
      n_checks++; if (act_q.size() !== 86) $display("FAIL zero_count: got %0d writes want 86", act_q.size()); else n_pass++;
      n_checks++; if (rd_q.size() !== 364) $display("FAIL zero_reads: got %0d reads want 364", rd_q.size()); else n_pass++;
      for (int i = 0; i < 86 && i < act_q.size(); i++) begin
         a = act_q[i]; e = exp_q[i];
         n_checks++;
         if (a !== e) $display("FAIL zero_word[%0d]: got req=%h addr=%0d data=%h want req=%h addr=%0d data=%h",
                               i, a[67:64], a[63:32], a[31:0], e[67:64], e[63:32], e[31:0]);
         else n_pass++;
      end
      if (act_q.size() >= 86) begin
         a = act_q[42];
         n_checks++; if ({a[67:64], a[63:32], a[23:0]} !== {4'h8, 32'd42, 24'd0}) $display("FAIL last_ch0: got req=%h addr=%0d data=%h want req=8 addr=42 low24=0", a[67:64], a[63:32], a[31:0]); else n_pass++;
         a = act_q[85];
         n_checks++; if ({a[67:64], a[63:32], a[23:0]} !== {4'h8, 32'd85, 24'd0}) $display("FAIL last_ch1: got req=%h addr=%0d data=%h want req=8 addr=85 low24=0", a[67:64], a[63:32], a[31:0]); else n_pass++;
      end
   endtask

   task automatic test_ramp();
      int cyc;
      logic [67:0] a, e;
      set_maps(1);
      clear_logs();
      run_job(1'b0, cyc);
      n_checks++; if (cyc < 1066 || cyc > 1070) $display("FAIL ramp_latency: got %0d cycles want 1068+-2", cyc); else n_pass++;
      n_checks++; if (act_q.size() !== 86) $display("FAIL ramp_count: got %0d writes want 86", act_q.size()); else n_pass++;
      if (act_q.size() >= 44) begin
         a = act_q[0];
         n_checks++; if (a[63:0] !== {32'd0, 32'h1B1D1F21}) $display("FAIL ramp_m3_0: got addr=%0d data=%h want addr=0 data=1b1d1f21", a[63:32], a[31:0]); else n_pass++;
         a = act_q[43];
         n_checks++; if (a[63:32] !== 32'd43) $display("FAIL ramp_ch1_base: got addr=%0d want 43", a[63:32]); else n_pass++;
      end
      for (int i = 0; i < 86 && i < act_q.size(); i++) begin
         a = act_q[i]; e = exp_q[i];
         n_checks++;
         if (a !== e) $display("FAIL ramp_word[%0d]: got req=%h addr=%0d data=%h want req=%h addr=%0d data=%h",
                               i, a[67:64], a[63:32], a[31:0], e[67:64], e[63:32], e[31:0]);
         else n_pass++;
      end
   endtask

   task automatic test_signed_window();
      int cyc;
      logic [67:0] a, e;
      logic [31:0] want0, want43;
`ifdef MAXPOOL_RELU_EN
      want0 = 32'h7F000000; want43 = 32'h00000000;
`else
      want0 = 32'h7F900000; want43 = 32'h80000000;
`endif
      set_maps(2);
      clear_logs();
      run_job(1'b0, cyc);
      n_checks++; if (act_q.size() !== 86) $display("FAIL win_count: got %0d writes want 86", act_q.size()); else n_pass++;
      if (act_q.size() >= 44) begin
         a = act_q[0];
         n_checks++; if (a[31:0] !== want0) $display("FAIL win_ch0_word0: got %h want %h", a[31:0], want0); else n_pass++;
         a = act_q[43];
         n_checks++; if (a[31:0] !== want43) $display("FAIL win_ch1_word0: got %h want %h", a[31:0], want43); else n_pass++;
      end
      for (int i = 0; i < 86 && i < act_q.size(); i++) begin
         a = act_q[i]; e = exp_q[i];
         n_checks++;
         if (a !== e) $display("FAIL win_word[%0d]: got req=%h addr=%0d data=%h want req=%h addr=%0d data=%h",
                               i, a[67:64], a[63:32], a[31:0], e[67:64], e[63:32], e[31:0]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_load();
      int cyc;
      logic [67:0] a, e;
      logic [32:0] first_rd;
      set_maps(1);
      clear_logs();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 200 && rd_q.size() < 20; i++) @(negedge clk);
      n_checks++; if (rd_q.size() < 20) $display("FAIL mid_reach_load: got %0d reads want >=20", rd_q.size()); else n_pass++;
      wr_in_rst = 0;
      rst = 1'b0;
      repeat (150) @(negedge clk);
      n_checks++;
      if ({finish, M1_R_req, M2_R_req, M3_W_req, M1_addr, M2_addr, M3_addr, M3_W_data} !== 135'd0)
         $display("FAIL mid_outputs_in_reset: got fin=%b r1=%b r2=%b w=%h a3=%h d3=%h want all 0",
                  finish, M1_R_req, M2_R_req, M3_W_req, M3_addr, M3_W_data);
      else n_pass++;
      repeat (150) @(negedge clk);
      n_checks++; if (wr_in_rst !== 0) $display("FAIL mid_writes_in_reset: got %0d want 0", wr_in_rst); else n_pass++;
      rst = 1'b1;
      clear_logs();
      repeat (20) @(negedge clk);
      n_checks++; if (rd_q.size() !== 0) $display("FAIL mid_no_resume: got %0d reads want 0", rd_q.size()); else n_pass++;
      clear_logs();
      run_job(1'b0, cyc);
      first_rd = (rd_q.size() > 0) ? rd_q[0] : 33'h1FFFFFFFF;
      n_checks++; if (first_rd !== 33'd0) $display("FAIL mid_restart_addr: got %h want M1 addr 0", first_rd); else n_pass++;
      n_checks++; if (act_q.size() !== 86) $display("FAIL mid_count: got %0d writes want 86", act_q.size()); else n_pass++;
      for (int i = 0; i < 86 && i < act_q.size(); i++) begin
         a = act_q[i]; e = exp_q[i];
         n_checks++;
         if (a !== e) $display("FAIL mid_word[%0d]: got req=%h addr=%0d data=%h want req=%h addr=%0d data=%h",
                               i, a[67:64], a[63:32], a[31:0], e[67:64], e[63:32], e[31:0]);
         else n_pass++;
      end
   endtask

   task automatic test_start_held();
      int cyc, drops;
      logic [67:0] a, e;
      set_maps(1);
      clear_logs();
      run_job(1'b1, cyc);
      n_checks++; if (finish !== 1'b1) $display("FAIL held_finish: got %b want 1", finish); else n_pass++;
      n_checks++; if (act_q.size() !== 86) $display("FAIL held_count: got %0d writes want 86", act_q.size()); else n_pass++;
      clear_logs();
      drops = 0;
      repeat (50) begin
         @(negedge clk);
         if (finish !== 1'b1) drops++;
      end
      n_checks++; if (drops !== 0) $display("FAIL held_finish_stays: got %0d low cycles want 0", drops); else n_pass++;
      n_checks++; if (rd_q.size() !== 0) $display("FAIL held_no_reads: got %0d reads want 0", rd_q.size()); else n_pass++;
      n_checks++; if (act_q.size() !== 0) $display("FAIL held_no_writes: got %0d writes want 0", act_q.size()); else n_pass++;
      start = 1'b0;
      @(negedge clk);
      n_checks++; if (finish !== 1'b0) $display("FAIL drop_finish: got %b want 0", finish); else n_pass++;
      clear_logs();
      run_job(1'b0, cyc);
      n_checks++; if (cyc < 1066 || cyc > 1070) $display("FAIL rerun_latency: got %0d cycles want 1068+-2", cyc); else n_pass++;
      n_checks++; if (act_q.size() !== 86) $display("FAIL rerun_count: got %0d writes want 86", act_q.size()); else n_pass++;
      for (int i = 0; i < 86 && i < act_q.size(); i++) begin
         a = act_q[i]; e = exp_q[i];
         n_checks++;
         if (a !== e) $display("FAIL rerun_word[%0d]: got req=%h addr=%0d data=%h want req=%h addr=%0d data=%h",
                               i, a[67:64], a[63:32], a[31:0], e[67:64], e[63:32], e[31:0]);
         else n_pass++;
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_zero_maps();
      test_ramp();
      test_signed_window();
      test_reset_mid_load();
      test_start_held();
      n_checks++; if (iso_err !== 0) $display("FAIL port_isolation: got %0d bad cycles want 0", iso_err); else n_pass++;
      n_checks++; if (bad_rd !== 0) $display("FAIL read_range: got %0d out-of-map reads want 0", bad_rd); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
